md_unit: RTL and testbench

Multiply/divide controller for the five-stage MIPS pipeline. It sits beside the ALU in the E stage and owns the HI/LO registers. It sequences multi-cycle MULT/MULTU/DIV/DIVU operations with a latency counter. It raises the D-stage stall request that keeps any later multiply/divide-class instruction from entering E while an operation is in flight.

---
 rtl/md_unit.sv | 219 +++++++++++++++++++++
 tb/tb_md_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit -- multiply/divide controller for the E stage of the MIPS pipeline.
//
// Owns the HI/LO registers. MULT/MULTU/DIV/DIVU are evaluated in the cycle
// they are accepted. The result is parked in pending registers. A down-counter
// then models the multi-cycle latency, and the result is committed to HI/LO
// when the counter expires. While an operation is in flight, any
// multiply/divide-class instruction in D is held back with stall_md.
//
// Parameters:
//   MULT_CYCLES  busy cycles for MULT/MULTU (>= 1)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (>= 1)
//
// Ports:
//   clk       clock, rising edge
//   rst_n     asynchronous active-low reset
//   md_valid  E-stage instruction is valid and multiply/divide-class
//   md_op     E-stage op: 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO,
//             7 MTHI, 8 MTLO; anything else is a no-op
//   rs_val    forwarded rs operand
//   rt_val    forwarded rt operand
//   d_is_md   D-stage instruction is multiply/divide-class
//   busy      an operation is in flight
//   stall_md  stall request to the hazard unit
//   hi, lo    architectural HI/LO registers
//   md_out    MFHI/MFLO read data (0 for any other op)
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        md_valid,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   hi_reg, lo_reg;
  logic [31:0]   p_hi_reg, p_lo_reg;
  logic          dz_reg;

  logic          is_arith;
  logic          is_div;
  logic          start;
  logic          commit;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign busy     = (state_reg == RUN);
  assign is_arith = (md_op == OP_MULT) || (md_op == OP_MULTU) ||
                    (md_op == OP_DIV)  || (md_op == OP_DIVU);
  assign is_div   = (md_op == OP_DIV) || (md_op == OP_DIVU);
  assign start    = md_valid & ~busy & is_arith;
  assign stall_md = d_is_md & (busy | start);

  // ---------------------------------------------------------------------------
  // Arithmetic, evaluated in the start cycle
  // ---------------------------------------------------------------------------
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               div_signed;
  logic               a_neg, b_neg;
  logic [31:0]        divisor;
  logic [31:0]        mag_a, mag_b;
  logic [31:0]        q_mag, r_mag;
  logic [31:0]        quot, rem;
  logic [31:0]        res_hi, res_lo;

  // Sign-extend to 64 bits before multiplying so the product is exact.
  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed division is done on magnitudes, then the signs are applied. This
  // handles 0x80000000 / -1 without overflow: the magnitude 0x80000000 is
  // representable unsigned, and both signs negative leave it un-negated.
  // A zero divisor is replaced by 1 so the datapath never sees X; the
  // divide-by-zero flag suppresses the commit instead.
  assign div_signed = (md_op == OP_DIV);
  assign a_neg      = div_signed & rs_val[31];
  assign b_neg      = div_signed & rt_val[31];
  assign divisor    = (rt_val == 32'd0) ? 32'd1 : rt_val;
  assign mag_a      = a_neg ? (~rs_val + 32'd1) : rs_val;
  assign mag_b      = b_neg ? (~divisor + 32'd1) : divisor;
  assign q_mag      = mag_a / mag_b;
  assign r_mag      = mag_a % mag_b;
  assign quot       = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
  assign rem        = a_neg ? (~r_mag + 32'd1) : r_mag;

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV,
      OP_DIVU: begin
        res_hi = rem;
        res_lo = quot;
      end
      default: begin
        res_hi = 32'd0;
        res_lo = 32'd0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequencer: IDLE/RUN with latency down-counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    commit     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          cnt_next   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        end
      end
      RUN: begin
        // cnt == 1 marks the last busy cycle; the result lands on its
        // closing edge so the next start is accepted without a dead cycle.
        if (cnt_reg == CW'(1)) begin
          state_next = IDLE;
          cnt_next   = '0;
          commit     = 1'b1;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Pending result and HI/LO registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_hi_reg <= 32'd0;
      p_lo_reg <= 32'd0;
      dz_reg   <= 1'b0;
    end else if (start) begin
      p_hi_reg <= res_hi;
      p_lo_reg <= res_lo;
      dz_reg   <= is_div & (rt_val == 32'd0);
    end
  end

  // A commit and an MTxx can never coincide: commit only happens while busy,
  // and MTxx is only honoured while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_reg <= 32'd0;
      lo_reg <= 32'd0;
    end else if (commit) begin
      if (!dz_reg) begin
        hi_reg <= p_hi_reg;
        lo_reg <= p_lo_reg;
      end
    end else if (md_valid && !busy) begin
      if (md_op == OP_MTHI) hi_reg <= rs_val;
      if (md_op == OP_MTLO) lo_reg <= rs_val;
    end
  end

  assign hi = hi_reg;
  assign lo = lo_reg;

  // ---------------------------------------------------------------------------
  // MFHI/MFLO read port
  // ---------------------------------------------------------------------------
  always_comb begin
    md_out = 32'd0;
    case (md_op)
      OP_MFHI: md_out = hi_reg;
      OP_MFLO: md_out = lo_reg;
      default: md_out = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit -- directed bench for md_unit with a scoreboard of expected HI/LO
// results. Each expectation is queued when its operation is driven and is
// compared when the operation's busy window closes.
module tb_md_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        md_valid = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        d_is_md = 1'b0;
  logic        busy, stall_md;
  logic [31:0] hi, lo, md_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  md_unit #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .md_valid(md_valid),
    .md_op   (md_op),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .d_is_md (d_is_md),
    .busy    (busy),
    .stall_md(stall_md),
    .hi      (hi),
    .lo      (lo),
    .md_out  (md_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [31:0] eh, input logic [31:0] el);
    exp_t e;
    e.hi = eh;
    e.lo = el;
    sb.push_back(e);
  endtask

  task automatic sb_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed hi=%h lo=%h", tag, hi, lo);
    end else begin
      e = sb.pop_front();
      chk({tag, " hi"}, hi, e.hi);
      chk({tag, " lo"}, lo, e.lo);
      $display("txn %s: hi=%h lo=%h (expected hi=%h lo=%h)", tag, hi, lo, e.hi, e.lo);
    end
  endtask

  // Called at a falling edge (inside cycle T). Drives one arithmetic op and
  // checks busy/stall through T+N and the committed result in T+N+1.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n, input logic d,
                        input logic [31:0] eh, input logic [31:0] el);
    md_valid = 1'b1;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    d_is_md  = d;
    sb_push(eh, el);
    #1;
    chk({tag, " stall T"}, 32'(stall_md), 32'(d));
    @(negedge clk);
    md_valid = 1'b0;
    md_op    = 4'd0;
    for (int i = 1; i <= n; i++) begin
      chk($sformatf("%s busy T+%0d", tag, i), 32'(busy), 32'd1);
      chk($sformatf("%s stall T+%0d", tag, i), 32'(stall_md), 32'(d));
      @(negedge clk);
    end
    chk({tag, " busy done"}, 32'(busy), 32'd0);
    chk({tag, " stall done"}, 32'(stall_md), 32'd0);
    sb_check(tag);
    d_is_md = 1'b0;
  endtask

  initial begin
    // Reset state, asserted from time 0.
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset stall", 32'(stall_md), 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Multiply, signed and unsigned, with and without a D-stage md instruction.
    run_op("MULT", 4'd1, 32'hFFFF_FFFF, 32'h0000_0002, MC, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("MULTU", 4'd2, 32'hFFFF_FFFF, 32'h0000_0002, MC, 1'b0, 32'h0000_0001, 32'hFFFF_FFFE);

    // Divide cases, including the signed overflow corner.
    run_op("DIV -7/2", 4'd3, 32'hFFFF_FFF9, 32'h0000_0002, DC, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("DIVU 7/2", 4'd4, 32'h0000_0007, 32'h0000_0002, DC, 1'b0, 32'h0000_0001, 32'h0000_0003);
    run_op("DIV ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, DC, 1'b0, 32'h0000_0000, 32'h8000_0000);

    // MTHI/MTLO preload, visible in the next cycle, then read back via MF ops.
    md_valid = 1'b1;
    md_op    = 4'd7;
    rs_val   = 32'h0000_1234;
    @(negedge clk);
    chk("MTHI hi", hi, 32'h0000_1234);
    md_op  = 4'd8;
    rs_val = 32'h0000_5678;
    @(negedge clk);
    chk("MTLO lo", lo, 32'h0000_5678);
    md_valid = 1'b0;
    md_op    = 4'd5;
    #1;
    chk("MFHI md_out", md_out, 32'h0000_1234);
    md_op = 4'd6;
    #1;
    chk("MFLO md_out", md_out, 32'h0000_5678);
    md_op = 4'd0;
    #1;
    chk("NONE md_out", md_out, 32'd0);
    @(negedge clk);

    // Divide by zero keeps HI/LO untouched after the full busy window.
    run_op("DIVU /0", 4'd4, 32'h0000_0063, 32'h0000_0000, DC, 1'b0, 32'h0000_1234, 32'h0000_5678);

    // MULT 5*7 at T; ignored MULT at T+2 and MTHI at T+3; back-to-back at T+6.
    md_valid = 1'b1;
    md_op    = 4'd1;
    rs_val   = 32'd5;
    rt_val   = 32'd7;
    sb_push(32'd0, 32'd35);
    @(negedge clk);                       // T+1
    md_valid = 1'b0;
    chk("ovl busy T+1", 32'(busy), 32'd1);
    @(negedge clk);                       // T+2
    md_valid = 1'b1;
    md_op    = 4'd1;
    rs_val   = 32'd3;
    rt_val   = 32'd3;
    d_is_md  = 1'b0;
    #1;
    chk("ovl no start stall", 32'(stall_md), 32'd0);
    @(negedge clk);                       // T+3
    md_op  = 4'd7;
    rs_val = 32'hDEAD_BEEF;
    @(negedge clk);                       // T+4
    md_valid = 1'b0;
    md_op    = 4'd5;
    #1;
    chk("ovl MTHI ignored", hi, 32'h0000_1234);
    chk("ovl MFHI while busy", md_out, 32'h0000_1234);
    md_op = 4'd0;
    @(negedge clk);                       // T+5
    chk("ovl busy T+5", 32'(busy), 32'd1);
    @(negedge clk);                       // T+6
    chk("ovl busy T+6", 32'(busy), 32'd0);
    sb_check("MULT 5*7");
    md_valid = 1'b1;
    md_op    = 4'd1;
    rs_val   = 32'd3;
    rt_val   = 32'd3;
    sb_push(32'd0, 32'd9);
    @(negedge clk);                       // T+7
    md_valid = 1'b0;
    md_op    = 4'd0;
    for (int i = 7; i <= 11; i++) begin
      chk($sformatf("b2b busy T+%0d", i), 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk("b2b busy T+12", 32'(busy), 32'd0);
    sb_check("MULT 3*3");

    // Reset in the middle of a DIV: everything clears at once, no late commit.
    md_valid = 1'b1;
    md_op    = 4'd7;
    rs_val   = 32'h0000_AAAA;
    @(negedge clk);
    chk("pre-rst MTHI", hi, 32'h0000_AAAA);
    md_op  = 4'd3;
    rs_val = 32'd100;
    rt_val = 32'd7;
    sb_push(32'd0, 32'd0);
    @(negedge clk);                       // T+1
    md_valid = 1'b0;
    md_op    = 4'd0;
    @(negedge clk);                       // T+2
    @(negedge clk);                       // T+3
    d_is_md = 1'b1;
    #1;
    rst_n = 1'b0;
    md_op = 4'd5;
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst stall", 32'(stall_md), 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    chk("rst MFHI", md_out, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    d_is_md = 1'b0;
    md_op   = 4'd0;
    repeat (DC + 2) @(negedge clk);
    chk("post-rst busy", 32'(busy), 32'd0);
    sb_check("DIV rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
